// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone SDRAM arbiter.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        GAP  = 2'd3
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam int unsigned MAX_BURST_DEF = 64;

    // Round-robin pick: on a tie the master not served last wins.
    function automatic arb_state_t arb_pick(input logic cyc0, input logic cyc1, input logic last_m1);
        arb_state_t pick;
        pick = IDLE;
        if (cyc0 && cyc1) begin
            pick = last_m1 ? GNT0 : GNT1;
        end else if (cyc0) begin
            pick = GNT0;
        end else if (cyc1) begin
            pick = GNT1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/wshb_arb_burst_cnt.sv
// Saturating per-grant ack counter with synchronous clear.
module wshb_arb_burst_cnt #(
    parameter int unsigned MAX   = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_W'(MAX))) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master round-robin Wishbone arbiter with bounded grant in front of the SDRAM slave.
// Optional ack/preemption statistics ports are enabled by defining WSHB_ARB_STATS_EN.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int unsigned ADR_W     = 32,
    parameter int unsigned DAT_W     = 32,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               m0_cyc,
    input  logic               m0_stb,
    input  logic               m0_we,
    input  logic [ADR_W-1:0]   m0_adr,
    input  logic [DAT_W-1:0]   m0_dat_ms,
    input  logic [DAT_W/8-1:0] m0_sel,
    input  logic [2:0]         m0_cti,
    input  logic [1:0]         m0_bte,
    output logic               m0_ack,
    output logic [DAT_W-1:0]   m0_dat_sm,
    input  logic               m1_cyc,
    input  logic               m1_stb,
    input  logic               m1_we,
    input  logic [ADR_W-1:0]   m1_adr,
    input  logic [DAT_W-1:0]   m1_dat_ms,
    input  logic [DAT_W/8-1:0] m1_sel,
    input  logic [2:0]         m1_cti,
    input  logic [1:0]         m1_bte,
    output logic               m1_ack,
    output logic [DAT_W-1:0]   m1_dat_sm,
    output logic               s_cyc,
    output logic               s_stb,
    output logic               s_we,
    output logic [ADR_W-1:0]   s_adr,
    output logic [DAT_W-1:0]   s_dat_ms,
    output logic [DAT_W/8-1:0] s_sel,
    output logic [2:0]         s_cti,
    output logic [1:0]         s_bte,
    input  logic               s_ack,
    input  logic [DAT_W-1:0]   s_dat_sm,
    output logic [1:0]         gnt
`ifdef WSHB_ARB_STATS_EN
    ,
    output logic [31:0]        stat_ack0,
    output logic [31:0]        stat_ack1,
    output logic [15:0]        stat_preempt
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state;
    arb_state_t       state_next;
    logic             last_m1;
    logic [CNT_W-1:0] burst_cnt;
    logic             at_limit;

    wshb_arb_burst_cnt #(
        .MAX   (MAX_BURST),
        .CNT_W (CNT_W)
    ) u_burst_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_next != state),
        .inc   (s_ack && ((state == GNT0) || (state == GNT1))),
        .count (burst_cnt)
    );

    // The ack in flight is the one that brings the count to MAX_BURST.
    assign at_limit = (burst_cnt >= CNT_W'(MAX_BURST - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last_m1 <= 1'b1;
        end else begin
            state <= state_next;
            if (state_next == GNT0) begin
                last_m1 <= 1'b0;
            end else if (state_next == GNT1) begin
                last_m1 <= 1'b1;
            end
        end
    end

    // GAP is a one-cycle bus release after preemption; it arbitrates like IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, GAP: state_next = arb_pick(m0_cyc, m1_cyc, last_m1);
            GNT0: begin
                if (!m0_cyc) begin
                    state_next = m1_cyc ? GNT1 : IDLE;
                end else if (s_ack && at_limit && m1_cyc) begin
                    state_next = GAP;
                end
            end
            GNT1: begin
                if (!m1_cyc) begin
                    state_next = m0_cyc ? GNT0 : IDLE;
                end else if (s_ack && at_limit && m0_cyc) begin
                    state_next = GAP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Slave-side mux and ack routing; nothing reaches the slave outside a grant.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_ms = '0;
        s_sel    = '0;
        s_cti    = CTI_CLASSIC;
        s_bte    = 2'b00;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        case (state)
            GNT0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_dat_ms = m0_dat_ms;
                s_sel    = m0_sel;
                s_cti    = m0_cti;
                s_bte    = m0_bte;
                m0_ack   = s_ack;
            end
            GNT1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_dat_ms = m1_dat_ms;
                s_sel    = m1_sel;
                s_cti    = m1_cti;
                s_bte    = m1_bte;
                m1_ack   = s_ack;
            end
            default: ;
        endcase
    end

    assign m0_dat_sm = s_dat_sm;
    assign m1_dat_sm = s_dat_sm;
    assign gnt       = {state == GNT1, state == GNT0};

`ifdef WSHB_ARB_STATS_EN
    logic preempt_c;
    assign preempt_c = (state_next == GAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ack0    <= '0;
            stat_ack1    <= '0;
            stat_preempt <= '0;
        end else begin
            if (m0_ack) begin
                stat_ack0 <= stat_ack0 + 32'd1;
            end
            if (m1_ack) begin
                stat_ack1 <= stat_ack1 + 32'd1;
            end
            if (preempt_c && (stat_preempt != 16'hFFFF)) begin
                stat_preempt <= stat_preempt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wshb_arbiter.sv
// Scoreboard bench for wshb_arbiter: m0 reads, m1 writes, a behavioural slave that acks every strobe.
module tb_wshb_arbiter;
    import wshb_arb_pkg::*;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = DAT_W / 8;
    localparam int unsigned MAXB  = 4;

    // Expected grant per cycle for the preemption and the post-reset/statistics scenarios.
    localparam logic [1:0] G3 [12] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                                       2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    localparam logic [1:0] G5 [18] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                                       2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01,
                                       2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};

    logic clk = 1'b0;
    logic rst_n;

    logic             m0_cyc, m0_stb, m0_we, m0_ack;
    logic [ADR_W-1:0] m0_adr;
    logic [DAT_W-1:0] m0_dat_ms, m0_dat_sm;
    logic [SEL_W-1:0] m0_sel;
    logic [2:0]       m0_cti;
    logic [1:0]       m0_bte;
    logic             m1_cyc, m1_stb, m1_we, m1_ack;
    logic [ADR_W-1:0] m1_adr;
    logic [DAT_W-1:0] m1_dat_ms, m1_dat_sm;
    logic [SEL_W-1:0] m1_sel;
    logic [2:0]       m1_cti;
    logic [1:0]       m1_bte;
    logic             s_cyc, s_stb, s_we, s_ack;
    logic [ADR_W-1:0] s_adr;
    logic [DAT_W-1:0] s_dat_ms, s_dat_sm;
    logic [SEL_W-1:0] s_sel;
    logic [2:0]       s_cti;
    logic [1:0]       s_bte;
    logic [1:0]       gnt;
`ifdef WSHB_ARB_STATS_EN
    logic [31:0]      stat_ack0, stat_ack1;
    logic [15:0]      stat_preempt;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] q0 [$];
    logic [71:0] qs [$];
    logic        force_ack = 1'b0;
    logic [1:0]  smp_gnt;
    logic        smp_cyc, smp_stb;

    wshb_arbiter #(
        .ADR_W     (ADR_W),
        .DAT_W     (DAT_W),
        .MAX_BURST (MAXB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_cyc    (m0_cyc),
        .m0_stb    (m0_stb),
        .m0_we     (m0_we),
        .m0_adr    (m0_adr),
        .m0_dat_ms (m0_dat_ms),
        .m0_sel    (m0_sel),
        .m0_cti    (m0_cti),
        .m0_bte    (m0_bte),
        .m0_ack    (m0_ack),
        .m0_dat_sm (m0_dat_sm),
        .m1_cyc    (m1_cyc),
        .m1_stb    (m1_stb),
        .m1_we     (m1_we),
        .m1_adr    (m1_adr),
        .m1_dat_ms (m1_dat_ms),
        .m1_sel    (m1_sel),
        .m1_cti    (m1_cti),
        .m1_bte    (m1_bte),
        .m1_ack    (m1_ack),
        .m1_dat_sm (m1_dat_sm),
        .s_cyc     (s_cyc),
        .s_stb     (s_stb),
        .s_we      (s_we),
        .s_adr     (s_adr),
        .s_dat_ms  (s_dat_ms),
        .s_sel     (s_sel),
        .s_cti     (s_cti),
        .s_bte     (s_bte),
        .s_ack     (s_ack),
        .s_dat_sm  (s_dat_sm),
        .gnt       (gnt)
`ifdef WSHB_ARB_STATS_EN
        ,
        .stat_ack0    (stat_ack0),
        .stat_ack1    (stat_ack1),
        .stat_preempt (stat_preempt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic m0_start(input logic [31:0] adr);
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_sel = 4'hF;
        m0_cti = CTI_CLASSIC; m0_bte = 2'b00; m0_adr = adr; m0_dat_ms = '0;
        q0.push_back(rd_data(adr));
    endtask

    task automatic m1_start(input logic [31:0] adr, input logic [31:0] dat);
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 4'hF;
        m1_cti = CTI_END; m1_bte = 2'b00; m1_adr = adr; m1_dat_ms = dat;
        qs.push_back({1'b1, 4'hF, CTI_END, adr, dat});
    endtask

    task automatic m0_stop();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
        q0.delete();
    endtask

    task automatic m1_stop();
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        qs.delete();
    endtask

    // One bus cycle: slave responds at negedge, acks scored just after, masters advance after posedge.
    task automatic cycle();
        logic a0, a1;
        @(negedge clk);
        s_ack    = force_ack | (s_cyc & s_stb);
        s_dat_sm = rd_data(s_adr);
        #1;
        smp_gnt = gnt; smp_cyc = s_cyc; smp_stb = s_stb;
        a0 = m0_ack; a1 = m1_ack;
        if (a0) begin
            check_eq("m0_ack_gnt", gnt, 2'b01);
            check_eq("m0_s_we", s_we, 1'b0);
            if (q0.size() == 0) check_eq("m0_unexpected_ack", 1'b1, 1'b0);
            else check_eq("m0_rdata", m0_dat_sm, q0.pop_front());
        end
        if (a1) begin
            check_eq("m1_ack_gnt", gnt, 2'b10);
            if (qs.size() == 0) check_eq("m1_unexpected_ack", 1'b1, 1'b0);
            else check_eq("slave_wr_beat", {s_we, s_sel, s_cti, s_adr, s_dat_ms}, qs.pop_front());
        end
        @(posedge clk);
        #1;
        if (a0 && m0_cyc) begin
            m0_adr = m0_adr + 32'd4;
            q0.push_back(rd_data(m0_adr));
        end
        if (a1 && m1_cyc) begin
            m1_adr    = m1_adr + 32'd4;
            m1_dat_ms = m1_dat_ms + 32'd1;
            qs.push_back({1'b1, m1_sel, m1_cti, m1_adr, m1_dat_ms});
        end
    endtask

    task automatic apply_reset();
        m0_stop(); m1_stop();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_ms = '0; m0_sel = '0; m0_cti = '0; m0_bte = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_ms = '0; m1_sel = '0; m1_cti = '0; m1_bte = '0;
        s_dat_sm = '0;
        rst_n = 1'b0;
        s_ack = 1'b1;
        #2;
        check_eq("rst_gnt", gnt, 2'b00);
        check_eq("rst_s_cyc_stb_we", {s_cyc, s_stb, s_we}, 3'b000);
        check_eq("rst_acks", {m0_ack, m1_ack}, 2'b00);
        s_ack = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester: one-cycle grant latency, unbroken stream past MAX_BURST.
        m0_start(32'h0000_1000);
        cycle();
        check_eq("t1_latency_s_cyc", smp_cyc, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cycle();
            check_eq("t1_stream_gnt", smp_gnt, 2'b01);
            check_eq("t1_stream_s_stb", smp_stb, 1'b1);
        end
        m0_stop();
        cycle();
        check_eq("t1_drop_s_cyc", smp_cyc, 1'b0);
        cycle();
        check_eq("t1_idle_gnt", smp_gnt, 2'b00);

        // Simultaneous request after reset: m0 first, then m1 with no idle cycle.
        apply_reset();
        m0_start(32'h0000_2000);
        m1_start(32'h0000_0300, 32'h1234_5678);
        for (int c = 1; c <= 5; c++) begin
            cycle();
            check_eq("t2_gnt", smp_gnt, (c == 1) ? 2'b00 : (c == 5) ? 2'b10 : 2'b01);
            check_eq("t2_s_cyc", smp_cyc, (c == 2 || c == 3 || c == 5) ? 1'b1 : 1'b0);
            if (c == 3) m0_stop();
        end
        m1_stop();
        cycle();
        cycle();
        check_eq("t2_idle_gnt", smp_gnt, 2'b00);

        // Preemption after MAX_BURST acks with a one-cycle gap; stray acks in IDLE/GAP are ignored.
        apply_reset();
        force_ack = 1'b1;
        m0_start(32'h0000_3000);
        for (int c = 1; c <= 12; c++) begin
            cycle();
            check_eq("t3_gnt", smp_gnt, G3[c-1]);
            check_eq("t3_s_cyc", smp_cyc, (G3[c-1] != 2'b00) ? 1'b1 : 1'b0);
            if (c == 3) m1_start(32'h0000_0100, 32'hDEAD_BEEF);
        end
        force_ack = 1'b0;
        check_eq("t3_m0_resume_adr", m0_adr, 32'h0000_3014);
        m0_stop(); m1_stop();
        cycle();
        cycle();
        check_eq("t3_idle_gnt", smp_gnt, 2'b00);

        // Asynchronous reset in the middle of a grant.
        apply_reset();
        m0_start(32'h0000_5000);
        cycle();
        cycle();
        #2;
        s_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_s_cyc_stb", {s_cyc, s_stb}, 2'b00);
        check_eq("arst_acks", {m0_ack, m1_ack}, 2'b00);
        check_eq("arst_gnt", gnt, 2'b00);
        q0.delete();
        q0.push_back(rd_data(m0_adr));
        m1_start(32'h0000_0600, 32'hA5A5_0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            cycle();
            check_eq("t5_gnt", smp_gnt, G5[c-1]);
            check_eq("t5_s_cyc", smp_cyc, (G5[c-1] != 2'b00 && c != 10 && c != 17) ? 1'b1 : 1'b0);
            if (c == 9) m1_stop();
            if (c == 16) m0_stop();
        end
`ifdef WSHB_ARB_STATS_EN
        check_eq("stat_ack0", stat_ack0, 32'd10);
        check_eq("stat_ack1", stat_ack1, 32'd3);
        check_eq("stat_preempt", stat_preempt, 16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wshb_arbiter.md
Name: wshb_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that shares the SDRAM Wishbone port between the video frame reader (m0) and the frame writer/pattern generator (m1).
- Round-robin between the two masters, with a bounded grant: the video reader holds cyc permanently, so the other master is never starved.
- Sits between both masters and the SDRAM controller slave port, in the 100 MHz bus clock domain.

Parameters:
- ADR_W, 32, address width.
- DAT_W, 32, data width; sel width is DAT_W/8.
- MAX_BURST, 64, maximum acks a master may take while the other master is requesting.

Ports:
- clk  in  1  Wishbone bus clock.
- rst_n  in  1  Asynchronous active-low reset.
- mN_cyc, mN_stb, mN_we  in  1 each  Master N (N = 0, 1) bus-cycle, strobe and write enable.
- mN_adr  in  ADR_W  Master N address.
- mN_dat_ms  in  DAT_W  Master N write data.
- mN_sel  in  DAT_W/8  Master N byte select.
- mN_cti  in  3  Master N cycle type.
- mN_bte  in  2  Master N burst type.
- mN_ack  out  1  Acknowledge routed to master N.
- mN_dat_sm  out  DAT_W  Read data to master N.
- s_cyc, s_stb, s_we  out  1 each  Slave bus-cycle, strobe and write enable.
- s_adr  out  ADR_W  Slave address.
- s_dat_ms  out  DAT_W  Slave write data.
- s_sel  out  DAT_W/8  Slave byte select.
- s_cti  out  3  Slave cycle type.
- s_bte  out  2  Slave burst type.
- s_ack  in  1  Slave acknowledge.
- s_dat_sm  in  DAT_W  Slave read data.
- gnt  out  2  One-hot current grant, for debug.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - state = IDLE, gnt = 00.
  - last served = m1, so m0 wins the first tie.
  - burst counter = 0.
  - s_cyc = s_stb = 0; s_we = 0.
  - m0_ack = m1_ack = 0.
- State machine: IDLE, GNT0, GNT1.
- IDLE:
  - One master with cyc=1 → grant it next cycle.
  - Both masters with cyc=1 → grant the master not served last.
  - Grant latency is 1 cycle from cyc to s_cyc.
- GNTk datapath:
  - Slave outputs are combinationally muxed from master k.
  - mk_ack = s_ack. The other master's ack is held at 0.
  - mN_dat_sm = s_dat_sm for both masters (harmless to the ungranted one).
- GNTk burst counter: increments on each s_ack; saturates at MAX_BURST.
- GNTk transitions:
  - mk_cyc falls, other master requesting → GNTother next cycle (no idle cycle).
  - mk_cyc falls, other master not requesting → IDLE.
  - Counter has reached MAX_BURST, the current cycle sees s_ack, and the other master's cyc=1 → preempt to GNTother next cycle.
  - The counter resets on every grant change.
- Preemption:
  - Occurs only on an ack boundary, never mid-beat.
  - The slave sees s_cyc=0 for exactly one cycle between grants; the arbiter passes through a 1-cycle gap before entering GNTother.
  - The preempted master keeps cyc/stb asserted and simply sees no ack until re-granted. No data is lost.
- Ungranted master: s_stb/s_cyc are never driven from it.
- s_ack arriving in IDLE or in the gap cycle: ignored, not forwarded to either master.
- Single requester: the counter saturates and there is no preemption. The video reader streams indefinitely.
- Reset mid-transfer: all outputs return to reset values asynchronously. Both masters' pending transactions restart after reset.

Optional Feature:
- Macro: WSHB_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_ack0 and stat_ack1 (32 bits each), counting acks delivered per master (wrap-around).
  - Adds output stat_preempt (16 bits, saturating), counting forced preemptions.
  - All three are reset to 0 by rst_n.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package wshb_arb_pkg:
  - enum arb_state_t {IDLE, GNT0, GNT1, GAP}.
  - CTI_CLASSIC = 3'b000 and CTI_END = 3'b111.
  - Default MAX_BURST constant.
- Optional sub-module wshb_arb_burst_cnt: saturating ack counter with clear. Everything else stays flat.

Test Plan:
- Reset, then m0_cyc=stb=1 only; slave acks every cycle → s_cyc rises 1 cycle later, m0 receives every ack, gnt=01, m1_ack stays 0.
- Both masters request in the same cycle after reset → m0 is granted first. After m0 drops cyc, m1 is granted on the next cycle with no IDLE cycle.
- m0 streaming continuously, m1 raises cyc; MAX_BURST=4 → after the 4th m0 ack, s_cyc=0 for one cycle, then gnt=10 and m1 receives acks. m0_adr is held and its data is resumed on re-grant.
- m1 write (we=1, adr=0x100, dat=0xDEADBEEF, sel=0xF) → the slave sees exactly those values while gnt=10. m0 sees no ack during the m1 grant.
- rst_n pulsed low asynchronously mid-grant → s_cyc, s_stb and both acks are 0 immediately. gnt=00; first grant after release goes to m0.
- With WSHB_ARB_STATS_EN: 10 m0 acks, 3 m1 acks, 1 preemption → stat_ack0=10, stat_ack1=3, stat_preempt=1.
